ps2_key_frontend: RTL and testbench
===================================

Name: ps2_key_frontend

Overview:
- Upstream stage of the PS/2 keyboard display path. Samples the raw PS/2 clock and data lines in the system clock domain and deserialises 11-bit device-to-host frames.
- Tracks the F0 (break) and E0 (extended) prefixes and presents a held key state to the seven-segment display stage: scan_code, asc_num, key_released.
- Also provides strobes and error flags for debug and for counters.

Parameters:
- TIMEOUT_CYC, 50000, system-clock cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages on ps2_clk/ps2_data before edge detection (legal 2..4).

Ports:
- clk  in  1  system clock; all state on posedge
- clrn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from connector, asynchronous
- ps2_data  in  1  raw PS/2 data from connector, asynchronous
- scan_code  out  8  last accepted make/break code byte, prefixes stripped
- asc_num  out  8  ASCII of scan_code from lookup; 8'h00 if unmapped or extended
- key_released  out  1  1 from break completion until next make
- extended  out  1  last accepted code was E0-prefixed
- key_valid  out  1  one-cycle strobe on every accepted make or break
- repeat_make  out  1  one-cycle strobe when a make equals current scan_code while key_released=0 (typematic)
- frame_err  out  1  one-cycle strobe on parity/start/stop/timeout error

Behaviour:
- Reset (clrn=0, asynchronous): all outputs 0. Synchronisers loaded with 1 (idle bus). Bit counter 0. FSM in S_IDLE. Timeout counter 0.
- Sampling:
  - ps2_clk and ps2_data pass through SYNC_STAGES flops.
  - A falling edge is synced_prev=1 and synced_now=0.
  - Data is sampled on that same cycle.
- Frame receive: one 11-bit frame is start(0), D0..D7 LSB first, odd parity, stop(1). Each falling edge shifts one bit and increments bit_cnt (0..10).
- Frame check on the 11th bit:
  - start==0, stop==1 and ^{D,parity}==1 -> byte accepted one cycle later.
  - Otherwise frame_err pulses and the byte is dropped.
  - bit_cnt returns to 0 in either case.
- Timeout:
  - The counter clears on every falling edge and counts while bit_cnt!=0.
  - On reaching TIMEOUT_CYC-1: bit_cnt<=0, frame_err pulses, prefix FSM forced to S_IDLE.
  - No timeout while bit_cnt==0.
- Prefix FSM (acts on accepted bytes only):
  - S_IDLE: E0->S_EXT; F0->S_BRK; other byte->make(ext=0).
  - S_EXT: F0->S_EXTBRK; E0->stay; other->make(ext=1), then S_IDLE.
  - S_BRK: any non-prefix byte->break(ext=0), then S_IDLE. E0/F0 here -> frame_err, then S_IDLE.
  - S_EXTBRK: non-prefix byte->break(ext=1), then S_IDLE. Prefix byte -> frame_err, then S_IDLE.
- Make event (registered, same cycle as key_valid):
  - Updates scan_code<=byte, extended<=ext, key_released<=0.
  - asc_num<=lookup(byte) if ext=0, else 8'h00.
  - If byte==scan_code and key_released==0, repeat_make=1 instead and the outputs stay unchanged (value-identical).
- Break event:
  - scan_code<=byte, extended<=ext, asc_num recomputed, key_released<=1.
  - A break for a code different from the current scan_code is still accepted (no rollover tracking).
- Bytes AA, FA, EE, FE, 00, FF in S_IDLE (device status) are ignored: no strobe, no output change.
- Latency: key_valid rises 1 cycle after the synchronised 11th falling edge; total ≤ SYNC_STAGES+2 cycles from the raw edge.
- key_valid, repeat_make and frame_err never assert in the same cycle.
- Reset mid-frame discards all partial state. The first frame after clrn rises is received normally.

Decomposition:
- Package ps2_pkg holds:
  - localparams PS2_BREAK=8'hF0, PS2_EXT=8'hE0, the device-status byte list, FRAME_BITS=11;
  - FSM state encoding S_IDLE/S_EXT/S_BRK/S_EXTBRK (2 bits).
- One sub-module, ps2_scan2ascii: purely combinational 8-bit scan code (set 2) -> lowercase ASCII ROM, 0 for unmapped codes. Kept separate so other stages reuse it.

Test Plan:
- Frame 1C (parity 0) -> scan_code=1C, asc_num=61, key_released=0, key_valid one pulse; then F0,1C -> key_released=1, scan_code=1C, exactly one more key_valid.
- Make 1C sent three times, no break -> one key_valid followed by two repeat_make pulses; outputs unchanged.
- E0,75 then E0,F0,75 -> scan_code=75, extended=1, asc_num=00; key_released 0 then 1.
- Frame 1C with parity bit flipped -> frame_err pulse, no key_valid, outputs keep previous values. Frame with stop=0 -> same response.
- Send 5 bits then idle TIMEOUT_CYC cycles -> frame_err at count TIMEOUT_CYC-1; a following full frame 32 -> scan_code=32, asc_num=62.
- Drop clrn for 3 cycles after 6 bits of a frame -> all outputs 0 asynchronously; next full frame 45 -> scan_code=45, asc_num=30.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, state encoding and helpers for the PS/2
// keyboard front end and its neighbouring stages.
//   PS2_BREAK / PS2_EXT   : break (F0) and extended (E0) prefix bytes
//   PS2_STATUS_BYTES      : device status bytes ignored between keys
//   FRAME_BITS            : bits per device-to-host frame
//   ps2_state_e           : prefix tracking FSM states
//   is_status_byte()      : membership test against PS2_STATUS_BYTES
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int PS2_STATUS_COUNT = 6;
    localparam logic [7:0] PS2_STATUS_BYTES [PS2_STATUS_COUNT] =
        '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXT    = 2'd1,
        S_BRK    = 2'd2,
        S_EXTBRK = 2'd3
    } ps2_state_e;

    // True when the byte is a keyboard status/ack code rather than a key.
    function automatic logic is_status_byte(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_STATUS_COUNT; i++) begin
            hit = hit | (b == PS2_STATUS_BYTES[i]);
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_frontend_if.sv
// ps2_key_frontend_if: key-state bus from the PS/2 front end to the
// display stage.
//   scan_code[7:0] : last accepted make/break code, prefixes stripped
//   asc_num[7:0]   : lowercase ASCII of scan_code, 0 if unmapped/extended
//   key_released   : high from a break until the next make
//   extended       : last accepted code was E0-prefixed
//   key_valid      : one-cycle strobe per accepted make or break
//   repeat_make    : one-cycle strobe for a typematic repeat
//   frame_err      : one-cycle strobe on a bad or timed-out frame
// Modports: master = front end (drives), slave = consumer (reads).
interface ps2_key_frontend_if;

    logic [7:0] scan_code;
    logic [7:0] asc_num;
    logic       key_released;
    logic       extended;
    logic       key_valid;
    logic       repeat_make;
    logic       frame_err;

    modport master (
        output scan_code, asc_num, key_released, extended,
               key_valid, repeat_make, frame_err
    );

    modport slave (
        input  scan_code, asc_num, key_released, extended,
               key_valid, repeat_make, frame_err
    );

endinterface

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: combinational scan code set 2 -> lowercase ASCII ROM.
//   code[7:0]  : scan code byte (no prefixes)
//   ascii[7:0] : ASCII character, 8'h00 for codes with no mapping
module ps2_scan2ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
            8'h0D: ascii = 8'h09;  8'h76: ascii = 8'h1B;
            8'h4E: ascii = 8'h2D;  8'h55: ascii = 8'h3D;  8'h54: ascii = 8'h5B;
            8'h5B: ascii = 8'h5D;  8'h4C: ascii = 8'h3B;  8'h52: ascii = 8'h27;
            8'h41: ascii = 8'h2C;  8'h49: ascii = 8'h2E;  8'h4A: ascii = 8'h2F;
            8'h0E: ascii = 8'h60;  8'h5D: ascii = 8'h5C;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_frontend.sv
// ps2_key_frontend: samples the raw PS/2 lines, deserialises 11-bit
// device-to-host frames, strips F0/E0 prefixes and holds the key state
// for the display stage.
//   clk      : system clock, all state on posedge
//   clrn     : asynchronous active-low reset
//   ps2_clk  : raw PS/2 clock from the connector (asynchronous)
//   ps2_data : raw PS/2 data from the connector (asynchronous)
//   key      : ps2_key_frontend_if master (key state, strobes, errors)
module ps2_key_frontend
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_key_frontend_if.master key
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout;
    logic             frame_done;
    logic             frame_ok;
    logic [7:0]       rx_byte;
    logic [7:0]       asc_lookup;

    ps2_state_e state;
    ps2_state_e state_next;
    logic       ev_make;
    logic       ev_break;
    logic       ev_err;
    logic       ev_ext;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a
    // spurious falling edge straight out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // The 11th bit (stop) is never shifted in; it is checked live together
    // with the ten stored bits so the result can be registered on the
    // same edge. shift[0]=start, shift[8:1]=D0..D7, shift[9]=parity.
    assign frame_done = fall && (bit_cnt == 4'(FRAME_BITS - 1));
    assign frame_ok   = frame_done && !shift[0] && data_s && (^shift[9:1]);
    assign rx_byte    = shift[8:1];
    assign timeout    = !fall && (bit_cnt != 4'd0) &&
                        (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt <= 4'd0;
            shift   <= '0;
            to_cnt  <= '0;
        end else if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shift   <= {data_s, shift[9:1]};
            end
        end else if (bit_cnt != 4'd0) begin
            if (timeout) begin
                bit_cnt <= 4'd0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    ps2_scan2ascii u_scan2ascii (
        .code  (rx_byte),
        .ascii (asc_lookup)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A timeout abandons any half-seen prefix sequence. A bad frame alone
    // leaves the prefix state untouched.
    always_comb begin
        state_next = state;
        ev_make    = 1'b0;
        ev_break   = 1'b0;
        ev_err     = 1'b0;
        ev_ext     = 1'b0;
        if (timeout) begin
            ev_err     = 1'b1;
            state_next = S_IDLE;
        end else if (frame_done && !frame_ok) begin
            ev_err = 1'b1;
        end else if (frame_ok) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_next = S_EXT;
                    end else if (rx_byte == PS2_BREAK) begin
                        state_next = S_BRK;
                    end else if (!is_status_byte(rx_byte)) begin
                        ev_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_next = S_EXTBRK;
                    end else if (rx_byte != PS2_EXT) begin
                        ev_make    = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rx_byte == PS2_EXT || rx_byte == PS2_BREAK) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_break = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                S_EXTBRK: begin
                    if (rx_byte == PS2_EXT || rx_byte == PS2_BREAK) begin
                        ev_err = 1'b1;
                    end else begin
                        ev_break = 1'b1;
                        ev_ext   = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // A make matching the held, still-pressed key is a typematic repeat:
    // it only strobes repeat_make and leaves the held state alone.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key.scan_code    <= 8'h00;
            key.asc_num      <= 8'h00;
            key.key_released <= 1'b0;
            key.extended     <= 1'b0;
            key.key_valid    <= 1'b0;
            key.repeat_make  <= 1'b0;
            key.frame_err    <= 1'b0;
        end else begin
            key.key_valid   <= 1'b0;
            key.repeat_make <= 1'b0;
            key.frame_err   <= ev_err;
            if (ev_make) begin
                if (rx_byte == key.scan_code && !key.key_released) begin
                    key.repeat_make <= 1'b1;
                end else begin
                    key.scan_code    <= rx_byte;
                    key.extended     <= ev_ext;
                    key.asc_num      <= ev_ext ? 8'h00 : asc_lookup;
                    key.key_released <= 1'b0;
                    key.key_valid    <= 1'b1;
                end
            end else if (ev_break) begin
                key.scan_code    <= rx_byte;
                key.extended     <= ev_ext;
                key.asc_num      <= ev_ext ? 8'h00 : asc_lookup;
                key.key_released <= 1'b1;
                key.key_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_frontend.sv
// tb_ps2_key_frontend: scoreboard bench for ps2_key_frontend. Stimulus
// pushes the expected strobe and resulting key state; an independent
// monitor pops and compares whenever the DUT strobes.
module tb_ps2_key_frontend;

    localparam int TIMEOUT = 1000;
    localparam int HALF    = 8;

    typedef enum logic [1:0] {EV_VALID, EV_REPEAT, EV_ERR, EV_MULTI} ev_e;

    typedef struct {
        ev_e        kind;
        logic [7:0] scan;
        logic [7:0] asc;
        logic       rel;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk      = 1'b0;
    logic clrn     = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_frontend_if key_bus ();

    ps2_key_frontend #(
        .TIMEOUT_CYC (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (key_bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation.
    ev_e  mon_kind;
    exp_t mon_exp;
    int   strobes;
    always @(negedge clk) begin
        if (clrn) begin
            strobes = int'(key_bus.key_valid) + int'(key_bus.repeat_make) +
                      int'(key_bus.frame_err);
            if (strobes != 0) begin
                if (strobes > 1)               mon_kind = EV_MULTI;
                else if (key_bus.key_valid)    mon_kind = EV_VALID;
                else if (key_bus.repeat_make)  mon_kind = EV_REPEAT;
                else                           mon_kind = EV_ERR;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got kind %0d, required none (t=%0t)",
                             mon_kind, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("event_kind", 8'(mon_kind), 8'(mon_exp.kind));
                    checkOutput("scan_code", key_bus.scan_code, mon_exp.scan);
                    checkOutput("asc_num", key_bus.asc_num, mon_exp.asc);
                    checkOutput("key_released", 8'(key_bus.key_released), 8'(mon_exp.rel));
                    checkOutput("extended", 8'(key_bus.extended), 8'(mon_exp.ext));
                end
            end
        end
    end

    task automatic pushExpected(input ev_e kind, input logic [7:0] scan,
                                input logic [7:0] asc, input logic rel,
                                input logic ext);
        exp_t e;
        e.kind = kind;
        e.scan = scan;
        e.asc  = asc;
        e.rel  = rel;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    // Drives the first n bits of f, LSB first, one bit per PS/2 clock.
    task automatic sendBits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par,
                                 input bit bad_stop);
        logic [10:0] f;
        logic        par;
        par = ~(^b);
        if (bad_par) par = ~par;
        f = {~bad_stop, par, b, 1'b0};
        sendBits(f, 11);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_scan_code", key_bus.scan_code, 8'h00);
        checkOutput("rst_asc_num", key_bus.asc_num, 8'h00);
        checkOutput("rst_key_released", 8'(key_bus.key_released), 8'h00);
        checkOutput("rst_extended", 8'(key_bus.extended), 8'h00);
        checkOutput("rst_key_valid", 8'(key_bus.key_valid), 8'h00);
        checkOutput("rst_repeat_make", 8'(key_bus.repeat_make), 8'h00);
        checkOutput("rst_frame_err", 8'(key_bus.frame_err), 8'h00);
    endtask

    initial begin
        #1 clrn = 1'b0;
        #2 checkResetState();
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] make/break 1C");
        pushExpected(EV_VALID, 8'h1C, 8'h61, 1'b0, 1'b0);
        applyStimulus(8'h1C, 0, 0);
        waitDrain("drain_make_1c");
        pushExpected(EV_VALID, 8'h1C, 8'h61, 1'b1, 1'b0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1C, 0, 0);
        waitDrain("drain_break_1c");

        $display("[TB] typematic 1C x3");
        pushExpected(EV_VALID, 8'h1C, 8'h61, 1'b0, 1'b0);
        pushExpected(EV_REPEAT, 8'h1C, 8'h61, 1'b0, 1'b0);
        pushExpected(EV_REPEAT, 8'h1C, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h1C, 0, 0);
        waitDrain("drain_repeat");

        $display("[TB] status byte AA ignored");
        applyStimulus(8'hAA, 0, 0);
        waitDrain("drain_status");

        $display("[TB] extended E0 75");
        pushExpected(EV_VALID, 8'h75, 8'h00, 1'b0, 1'b1);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        waitDrain("drain_ext_make");
        pushExpected(EV_VALID, 8'h75, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        waitDrain("drain_ext_break");

        $display("[TB] parity and stop errors");
        pushExpected(EV_ERR, 8'h75, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1, 0);
        waitDrain("drain_parity_err");
        pushExpected(EV_ERR, 8'h75, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h1C, 0, 1);
        waitDrain("drain_stop_err");

        $display("[TB] timeout after 5 bits");
        sendBits(11'b110_0011_1000, 5);
        repeat (TIMEOUT - 20) @(negedge clk);
        pushExpected(EV_ERR, 8'h75, 8'h00, 1'b1, 1'b1);
        waitDrain("drain_timeout");
        pushExpected(EV_VALID, 8'h32, 8'h62, 1'b0, 1'b0);
        applyStimulus(8'h32, 0, 0);
        waitDrain("drain_after_timeout");

        $display("[TB] reset mid-frame");
        sendBits(11'b100_1000_1010, 6);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1 checkResetState();
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        pushExpected(EV_VALID, 8'h45, 8'h30, 1'b0, 1'b0);
        applyStimulus(8'h45, 0, 0);
        waitDrain("drain_after_reset");

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
